// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared types and constants for the instruction-memory boot loader
package boot_pkg;

   // Boot sequencer states: two header bytes, word load, core running, rejected image
   typedef enum logic [2:0] {
      LEN_LO,
      LEN_HI,
      LOAD,
      RUN,
      ERROR
   } boot_state_t;

   // Header length in bytes (word count N, LSB first)
   localparam int BOOT_LEN_BYTES = 2;
   // Bytes packed into one instruction word
   localparam int BYTES_PER_WORD = 4;
   // Width of the word count and of the words-loaded counter
   localparam int BOOT_CNT_W     = 8 * BOOT_LEN_BYTES;

endpackage

// File: rtl/imem_boot_loader_word_packer.sv
// rtl/imem_boot_loader_word_packer.sv - little-endian byte-to-word packer with lane counter
module boot_word_packer
   import boot_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_clr,
   input  logic                          i_valid,
   input  logic [7:0]                    i_data,
   output logic                          o_word_valid,
   output logic [8*BYTES_PER_WORD-1:0]   o_word_data
);

   localparam int                LANE_W    = $clog2(BYTES_PER_WORD);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

   logic [LANE_W-1:0]            r_lane;
   logic [8*BYTES_PER_WORD-1:0]  r_word;

   // Place each accepted byte into its lane; the lane wraps after the top byte
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_lane <= '0;
         r_word <= '0;
      end else if (i_valid) begin
         r_word[8*r_lane +: 8] <= i_data;
         r_lane <= (r_lane == LAST_LANE) ? '0 : r_lane + 1'b1;
      end
   end

   // The completed word includes the byte arriving this cycle so it can be written at the next edge
   always_comb begin
      o_word_data                = r_word;
      o_word_data[8*r_lane +: 8] = i_data;
      o_word_valid               = i_valid && (r_lane == LAST_LANE);
   end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot sequencer that loads a byte-stream image into instruction memory
module imem_boot_loader
   import boot_pkg::*;
#(
   parameter int IMEM_DEPTH = 256,
   parameter int ADDR_W     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             rx_data_i,
   input  logic                   rx_valid_i,
   output logic                   rx_ready_o,
   input  logic                   reload_i,
   output logic                   imem_we_o,
   output logic [ADDR_W-1:0]      imem_addr_o,
   output logic [31:0]            imem_wdata_o,
   output logic                   core_rst_n_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic [BOOT_CNT_W-1:0]  words_loaded_o
);

   localparam logic [BOOT_CNT_W-1:0] DEPTH_N = BOOT_CNT_W'(IMEM_DEPTH);

   boot_state_t              r_state;
   boot_state_t              w_next_state;

   logic [BOOT_CNT_W-1:0]    r_len;
   logic [ADDR_W:0]          r_word_idx;
   logic                     r_we;
   logic [ADDR_W-1:0]        r_addr;
   logic [31:0]              r_wdata;
   logic                     r_core_rst_n;
   logic [BOOT_CNT_W-1:0]    r_words_loaded;

   logic                     w_accept;
   logic                     w_xfer;
   logic                     w_load_xfer;
   logic                     w_word_valid;
   logic [31:0]              w_word_data;
   logic                     w_last_word;
   logic                     w_restart;
   logic [BOOT_CNT_W-1:0]    w_full_len;
   logic [BOOT_CNT_W-1:0]    w_idx_next;

   // Handshake and word-completion decode from the registered state
   always_comb begin
      w_accept    = (r_state == LEN_LO) || (r_state == LEN_HI) || (r_state == LOAD);
      rx_ready_o  = !rst && w_accept;
      w_xfer      = rx_valid_i && rx_ready_o;
      w_load_xfer = w_xfer && (r_state == LOAD);
      w_full_len  = {rx_data_i, r_len[7:0]};
      w_idx_next  = BOOT_CNT_W'(r_word_idx) + BOOT_CNT_W'(1);
      w_last_word = w_word_valid && (w_idx_next == r_len);
      w_restart   = reload_i && ((r_state == RUN) || (r_state == ERROR));
   end

   boot_word_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .i_clr        (w_restart),
      .i_valid      (w_load_xfer),
      .i_data       (rx_data_i),
      .o_word_valid (w_word_valid),
      .o_word_data  (w_word_data)
   );

   // Next-state logic; reload is honoured only once the image has finished or been rejected
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         LEN_LO: begin
            if (w_xfer) w_next_state = LEN_HI;
         end
         LEN_HI: begin
            if (w_xfer) begin
               if (w_full_len > DEPTH_N)          w_next_state = ERROR;
               else if (w_full_len == '0)         w_next_state = RUN;
               else                               w_next_state = LOAD;
            end
         end
         LOAD: begin
            if (w_last_word) w_next_state = RUN;
         end
         RUN: begin
            if (reload_i) w_next_state = LEN_LO;
         end
         ERROR: begin
            if (reload_i) w_next_state = LEN_LO;
         end
         default: w_next_state = LEN_LO;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= LEN_LO;
      else     r_state <= w_next_state;
   end

   // Header capture, memory write port, word counters and core reset release
   always_ff @(posedge clk) begin
      if (rst) begin
         r_len          <= '0;
         r_word_idx     <= '0;
         r_we           <= 1'b0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_core_rst_n   <= 1'b0;
         r_words_loaded <= '0;
      end else begin
         r_we <= w_word_valid;
         if (w_xfer && (r_state == LEN_LO)) r_len[7:0]  <= rx_data_i;
         if (w_xfer && (r_state == LEN_HI)) r_len[15:8] <= rx_data_i;
         if (w_word_valid) begin
            r_addr         <= r_word_idx[ADDR_W-1:0];
            r_wdata        <= w_word_data;
            r_word_idx     <= r_word_idx + 1'b1;
            r_words_loaded <= r_words_loaded + 1'b1;
         end
         if (w_restart) begin
            r_word_idx     <= '0;
            r_words_loaded <= '0;
         end
         // RUN is entered on the edge of the final write, so release lands one cycle after it
         r_core_rst_n <= (r_state == RUN) && !reload_i;
      end
   end

   assign imem_we_o      = r_we;
   assign imem_addr_o    = r_addr;
   assign imem_wdata_o   = r_wdata;
   assign core_rst_n_o   = r_core_rst_n;
   assign words_loaded_o = r_words_loaded;
   assign busy_o         = w_accept;
   assign done_o         = (r_state == RUN);
   assign err_o          = (r_state == ERROR);

endmodule
